// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto one AHB-Lite master port.
// Latency: grant combinational in the address phase; response in the following data phase(s).
// Backpressure: HREADY=0 stalls grants and data-phase completion; fetch is protected from data starvation.
module mem_port_arbiter #(
  parameter int unsigned FETCH_STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic [31:0] if_rdata,
  output logic        if_rvalid,
  output logic        if_err,
  // data port
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        d_err,
  // AHB-Lite master
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [3:0] STARVE_MAX    = 4'(FETCH_STARVE_MAX);

  // Who owns the transfer currently in its data phase.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  owner_e      dp_owner, dp_owner_nxt;
  logic        dp_write, dp_write_nxt;
  logic [3:0]  starve_cnt, starve_cnt_nxt;
  logic [31:0] hwdata_q, hwdata_nxt;

  logic dp_active;
  logic err_first;
  logic err_second;
  logic dp_done_ok;
  logic fetch_priority;
  logic sel_if;
  logic sel_d;

  assign dp_active      = (dp_owner != OWN_NONE);
  // First error cycle: the slave wants the pipeline emptied, so no new address phase.
  assign err_first      = dp_active & HRESP & ~HREADY;
  assign err_second     = dp_active & HRESP & HREADY;
  assign dp_done_ok     = dp_active & ~HRESP & HREADY;
  // Fetch jumps the queue once data has won FETCH_STARVE_MAX times in a row over it.
  assign fetch_priority = if_req & (starve_cnt == STARVE_MAX);

  // Pick this cycle's address-phase owner; nothing is presented during reset or the first error cycle.
  always_comb begin
    sel_if = 1'b0;
    sel_d  = 1'b0;
    if (!rst && !err_first) begin
      if (fetch_priority) begin
        sel_if = 1'b1;
      end else if (d_req) begin
        sel_d = 1'b1;
      end else if (if_req) begin
        sel_if = 1'b1;
      end
    end
  end

  // Drive the address phase of the selected requester, or an all-zero IDLE.
  always_comb begin
    HTRANS = HTRANS_IDLE;
    HADDR  = 32'h0;
    HWRITE = 1'b0;
    if (sel_d) begin
      HTRANS = HTRANS_NONSEQ;
      HADDR  = d_addr;
      HWRITE = d_write;
    end else if (sel_if) begin
      HTRANS = HTRANS_NONSEQ;
      HADDR  = if_addr;
    end
  end

  assign HSIZE  = 3'b010;
  assign HWDATA = hwdata_q;

  // A grant is the acceptance of the address phase: NONSEQ presented while the bus is ready.
  assign if_gnt = sel_if & HREADY;
  assign d_gnt  = sel_d & HREADY;

  // Data-phase completion is reported to whichever requester owns it.
  assign if_rvalid = (dp_owner == OWN_IF) & dp_done_ok;
  assign d_rvalid  = (dp_owner == OWN_D)  & dp_done_ok;
  assign if_err    = (dp_owner == OWN_IF) & err_second;
  assign d_err     = (dp_owner == OWN_D)  & err_second;
  // Read data is only passed through on a valid read completion; zero otherwise.
  assign if_rdata  = if_rvalid ? HRDATA : 32'h0;
  assign d_rdata   = (d_rvalid && !dp_write) ? HRDATA : 32'h0;

  // Next data-phase owner: advances only when the bus is ready, so wait states hold it.
  always_comb begin
    dp_owner_nxt = dp_owner;
    dp_write_nxt = dp_write;
    if (HREADY) begin
      if (if_gnt) begin
        dp_owner_nxt = OWN_IF;
        dp_write_nxt = 1'b0;
      end else if (d_gnt) begin
        dp_owner_nxt = OWN_D;
        dp_write_nxt = d_write;
      end else begin
        dp_owner_nxt = OWN_NONE;
        dp_write_nxt = 1'b0;
      end
    end
  end

  // Write data is latched at acceptance and held until the next accepted write.
  always_comb begin
    hwdata_nxt = hwdata_q;
    if (d_gnt && d_write) begin
      hwdata_nxt = d_wdata;
    end
  end

  // Count data grants taken while fetch waits; any fetch grant or withdrawn fetch resets it.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (if_gnt || !if_req) begin
      starve_cnt_nxt = 4'd0;
    end else if (d_gnt && (starve_cnt < STARVE_MAX)) begin
      starve_cnt_nxt = starve_cnt + 4'd1;
    end
  end

  // State registers; reset drops any in-flight transfer so it can never report back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_owner   <= OWN_NONE;
      dp_write   <= 1'b0;
      starve_cnt <= 4'd0;
      hwdata_q   <= 32'h0;
    end else begin
      dp_owner   <= dp_owner_nxt;
      dp_write   <= dp_write_nxt;
      starve_cnt <= starve_cnt_nxt;
      hwdata_q   <= hwdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
// Model keeps a queue of outstanding transfers and a count of data wins over a waiting fetch.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
module tb_mem_port_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic [31:0] if_rdata;
  logic        if_rvalid;
  logic        if_err;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_write;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        d_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.FETCH_STARVE_MAX(MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata),
    .if_rvalid(if_rvalid), .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_err(d_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of transfers awaiting their data phase (1=fetch, 2=data)
  initial begin
    int          q_who[$];
    bit          q_wr[$];
    int          fetch_waits;
    logic [31:0] m_hwdata;
    int          win;
    int          own;
    bit          own_wr;
    fetch_waits = 0;
    m_hwdata    = 32'h0;
    forever begin
      @(negedge clk);
      win = 0;
      if (rst) begin
        chk("rst_htrans", HTRANS, 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwrite", HWRITE, 0);
        chk("rst_hwdata", HWDATA, 0);
        chk("rst_resp", {if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err}, 0);
        chk("rst_rdata", if_rdata | d_rdata, 0);
      end else begin
        own    = (q_who.size() > 0) ? q_who[0] : 0;
        own_wr = (q_who.size() > 0) ? q_wr[0] : 1'b0;
        if (!(own != 0 && HRESP && !HREADY)) begin
          if (if_req && fetch_waits == MAX) win = 1;
          else if (d_req)                  win = 2;
          else if (if_req)                 win = 1;
        end
        chk("htrans", HTRANS, (win != 0) ? 2 : 0);
        chk("haddr", HADDR, (win == 2) ? d_addr : (win == 1) ? if_addr : 0);
        chk("hwrite", HWRITE, (win == 2) && d_write);
        chk("hsize", HSIZE, 3'b010);
        chk("hwdata", HWDATA, m_hwdata);
        chk("if_gnt", if_gnt, (win == 1) && HREADY);
        chk("d_gnt", d_gnt, (win == 2) && HREADY);
        chk("gnt_excl", if_gnt & d_gnt, 0);
        chk("if_rvalid", if_rvalid, (own == 1) && HREADY && !HRESP);
        chk("d_rvalid", d_rvalid, (own == 2) && HREADY && !HRESP);
        chk("if_err", if_err, (own == 1) && HREADY && HRESP);
        chk("d_err", d_err, (own == 2) && HREADY && HRESP);
        chk("if_rdata", if_rdata, ((own == 1) && HREADY && !HRESP) ? HRDATA : 0);
        if (!(own == 2 && own_wr))
          chk("d_rdata", d_rdata, ((own == 2) && HREADY && !HRESP) ? HRDATA : 0);
      end
      @(posedge clk);
      if (rst) begin
        q_who.delete();
        q_wr.delete();
        fetch_waits = 0;
        m_hwdata    = 32'h0;
      end else begin
        if (HREADY && q_who.size() > 0) begin
          void'(q_who.pop_front());
          void'(q_wr.pop_front());
        end
        if (win != 0 && HREADY) begin
          q_who.push_back(win);
          q_wr.push_back((win == 2) && d_write);
          if (win == 2 && d_write) m_hwdata = d_wdata;
        end
        if (!if_req || (win == 1 && HREADY)) fetch_waits = 0;
        else if (win == 2 && HREADY && fetch_waits < MAX) fetch_waits++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  // Directed scenarios with literal expectations
  initial begin
    logic [1:0] pat[10];
    logic [1:0] pat_exp[10];
    rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_addr = 0; d_write = 0;
    d_wdata = 0; HRDATA = 0; HREADY = 1'b1; HRESP = 1'b0;

    // reset holds everything idle even with a pending request
    step(); if_req = 1; if_addr = 32'h100; look();
    chk("lit_rst_gnt", if_gnt, 0);
    chk("lit_rst_htrans", HTRANS, 0);

    // first cycle after reset: fetch accepted, then responded
    step(); rst = 0; look();
    chk("lit_fetch_gnt", if_gnt, 1);
    chk("lit_fetch_htrans", HTRANS, 2'b10);
    chk("lit_fetch_haddr", HADDR, 32'h100);
    step(); if_req = 0; HRDATA = 32'h13; look();
    chk("lit_fetch_rvalid", if_rvalid, 1);
    chk("lit_fetch_rdata", if_rdata, 32'h13);
    step(); HRDATA = 32'hFFFF_0000; look();
    chk("lit_idle_rdata_zero", if_rdata, 0);

    // simultaneous requests: data write first, fetch in the next cycle
    step(); HRDATA = 0; if_req = 1; if_addr = 32'h104;
    d_req = 1; d_write = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; look();
    chk("lit_wr_dgnt", d_gnt, 1);
    chk("lit_wr_ifgnt", if_gnt, 0);
    chk("lit_wr_hwrite", HWRITE, 1);
    step(); d_req = 0; d_write = 0; d_wdata = 0; look();
    chk("lit_wr_hwdata", HWDATA, 32'hDEADBEEF);
    chk("lit_wr_drvalid", d_rvalid, 1);
    chk("lit_wr_then_ifgnt", if_gnt, 1);
    chk("lit_wr_then_haddr", HADDR, 32'h104);
    step(); if_req = 0; HRDATA = 32'h55; look();
    chk("lit_if_after_wr", if_rdata, 32'h55);
    chk("lit_hwdata_hold", HWDATA, 32'hDEADBEEF);

    // both held: four data grants then one fetch grant, repeating
    step(); HRDATA = 0; if_req = 1; if_addr = 32'h400; d_req = 1; d_addr = 32'h300;
    for (int i = 0; i < 10; i++) begin
      look();
      pat[i] = {if_gnt, d_gnt};
      pat_exp[i] = (i % 5 == 4) ? 2'b10 : 2'b01;
      if (i < 9) step();
    end
    for (int i = 0; i < 10; i++) chk($sformatf("lit_starve_pat%0d", i), pat[i], pat_exp[i]);
    step(); if_req = 0; d_req = 0; look();

    // data read with three wait states while a fetch is pending
    step(); d_req = 1; d_addr = 32'h500; if_req = 1; if_addr = 32'h600; look();
    chk("lit_ws_dgnt", d_gnt, 1);
    for (int k = 0; k < 3; k++) begin
      step(); d_req = 0; HREADY = 0; look();
      chk("lit_ws_htrans", HTRANS, 2'b10);
      chk("lit_ws_haddr", HADDR, 32'h600);
      chk("lit_ws_norvalid", d_rvalid, 0);
    end
    step(); HREADY = 1; HRDATA = 32'hCAFE0001; look();
    chk("lit_ws_drvalid", d_rvalid, 1);
    chk("lit_ws_drdata", d_rdata, 32'hCAFE0001);
    chk("lit_ws_ifgnt", if_gnt, 1);
    step(); if_req = 0; HRDATA = 32'h77; look();
    chk("lit_ws_ifrvalid", if_rvalid, 1);

    // two-cycle error response on a fetch
    step(); HRDATA = 0; if_req = 1; if_addr = 32'h700; look();
    chk("lit_err_gnt", if_gnt, 1);
    step(); if_addr = 32'h704; HRESP = 1; HREADY = 0; look();
    chk("lit_err1_htrans", HTRANS, 0);
    chk("lit_err1_gnt", if_gnt, 0);
    chk("lit_err1_noerr", if_err, 0);
    step(); if_req = 0; HREADY = 1; look();
    chk("lit_err2_err", if_err, 1);
    chk("lit_err2_norvalid", if_rvalid, 0);
    step(); HRESP = 0; look();
    chk("lit_err_done", if_err, 0);

    // reset during the data phase of a read
    step(); d_req = 1; d_addr = 32'h800; look();
    chk("lit_rr_dgnt", d_gnt, 1);
    step(); d_req = 0; HREADY = 0; if_req = 1; if_addr = 32'h900; look();
    chk("lit_rr_pending_htrans", HTRANS, 2'b10);
    rst = 1; #1;
    chk("lit_rr_htrans_now", HTRANS, 0);
    chk("lit_rr_haddr_now", HADDR, 0);
    step(); HREADY = 1; HRDATA = 32'h99; look();
    chk("lit_rr_in_rst", d_rvalid, 0);
    step(); rst = 0; if_req = 0; look();
    chk("lit_rr_after", d_rvalid, 0);
    chk("lit_rr_after_rdata", d_rdata, 0);
    step(); look();
    chk("lit_rr_after2", d_rvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
